// File: rtl/ca_pkg.sv
// ----------------------------------------------------------------------------
// ca_pkg
// Shared definitions for the MEM-stage SRAM controller.
//   DATA_W        : datapath width (32).
//   BASE_ADDR_DEF : default byte address that maps onto SRAM word 0.
//   state_t       : controller FSM state encoding (IDLE / ACCESS / DONE).
// ----------------------------------------------------------------------------
package ca_pkg;

   localparam int          DATA_W        = 32;
   localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/mem_stage_sram_ctrl.sv
// ----------------------------------------------------------------------------
// mem_stage_sram_ctrl
// MEM pipeline stage. Services LDR/STR against a single-port synchronous SRAM
// with a fixed multi-cycle access latency, and passes the ALU result,
// wb_enable and dest_reg straight through to the MEM/WB register.
//
// Ports:
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   alu_result_in       : byte address for loads/stores, otherwise ALU result
//   val_rm_in           : store data
//   mem_read_in/_write_in : load / store request (both set = treated as store)
//   wb_enable_in, dest_reg_in : pass-through
//   alu_result_out, mem_read_out, wb_enable_out, dest_reg_out : combinational
//                         copies of the matching inputs
//   mem_data_out        : registered load data, held until the next load ends
//   ready               : pipeline stall handshake (see below)
//   sram_addr/_wdata/_rdata/_ce_n/_we_n : SRAM interface, strobes active low
//
// Handshake: `ready` is the only flow-control signal. When ready=0 every
// upstream pipeline register (IF/ID/EXE) and MEM_stage_reg must hold, which
// keeps all *_in signals stable for the whole access. When ready=1 the
// pipeline advances on the next rising edge. A memory op therefore sees
// ready=0 for WAIT_CYCLES+1 cycles (request cycle + ACCESS cycles) followed by
// exactly one ready=1 cycle in DONE; non-memory ops never drop ready.
//
// The current FSM state is available as the internal signal `state` for
// debug observation.
// ----------------------------------------------------------------------------
module mem_stage_sram_ctrl
   import ca_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
   parameter int          ADDR_W      = 16,
   parameter int          WAIT_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       alu_result_in,
   input  logic [31:0]       val_rm_in,
   input  logic              mem_read_in,
   input  logic              mem_write_in,
   input  logic              wb_enable_in,
   input  logic [3:0]        dest_reg_in,
   output logic [31:0]       alu_result_out,
   output logic [31:0]       mem_data_out,
   output logic              mem_read_out,
   output logic              wb_enable_out,
   output logic [3:0]        dest_reg_out,
   output logic              ready,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_wdata,
   input  logic [31:0]       sram_rdata,
   output logic              sram_ce_n,
   output logic              sram_we_n
);

   localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

   state_t      state, state_nx;
   logic [3:0]  cnt;
   logic        req;
   logic        last_access;
   logic [31:0] byte_off;

   assign req         = mem_read_in | mem_write_in;
   assign last_access = (state == ACCESS) && (cnt == LAST_CNT);

   // Pass-through to MEM/WB.
   assign alu_result_out = alu_result_in;
   assign mem_read_out   = mem_read_in;
   assign wb_enable_out  = wb_enable_in;
   assign dest_reg_out   = dest_reg_in;

   // Word address: rebase, drop the byte offset, truncate (wraps, no bounds check).
   assign byte_off   = alu_result_in - BASE_ADDR;
   assign sram_addr  = ADDR_W'(byte_off >> 2);
   assign sram_wdata = val_rm_in;

   // Strobes are decoded from the registered state and the frozen inputs, so
   // they cannot glitch; outside ACCESS both stay deasserted.
   always_comb begin
      state_nx  = state;
      ready     = 1'b1;
      sram_ce_n = 1'b1;
      sram_we_n = 1'b1;
      case (state)
         IDLE: begin
            ready = ~req;  // freeze in the request cycle itself
            if (req) state_nx = ACCESS;
         end
         ACCESS: begin
            ready     = 1'b0;
            sram_ce_n = 1'b0;
            sram_we_n = ~mem_write_in;  // read+write together resolves to write
            if (cnt == LAST_CNT) state_nx = DONE;
         end
         DONE: begin
            // Pipeline advances on this edge; a back-to-back request is
            // picked up from IDLE, costing one extra freeze cycle.
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nx;
         if (state == IDLE && req) cnt <= 4'd0;
         else if (state == ACCESS) cnt <= cnt + 4'd1;
      end
   end

   // Load data is valid on sram_rdata only in the last ACCESS cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) mem_data_out <= 32'd0;
      else if (last_access && mem_read_in && !mem_write_in) mem_data_out <= sram_rdata;
   end

   // Simultaneous load and store is an upstream decode error.
   a_no_rd_wr: assert property (@(posedge clk) disable iff (rst)
                                !(mem_read_in && mem_write_in));

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_stage_sram_ctrl
// Bench for mem_stage_sram_ctrl. Two instances: dut0 (WAIT_CYCLES=4) and
// dut1 (WAIT_CYCLES=1), each with its own behavioural SRAM that presents read
// data only in the last access cycle and commits writes at its end.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge. Load results go through exp_q.
// ----------------------------------------------------------------------------
module tb_mem_stage_sram_ctrl;
   import ca_pkg::*;

   localparam int W0 = 4;
   localparam int W1 = 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ---------------- dut0 signals ----------------
   logic [31:0] alu_in0, rm_in0, alu_out0, mdata0, wdata0, rdata0;
   logic        rd_in0, wr_in0, wb_in0, rd_out0, wb_out0, rdy0, ce_n0, we_n0;
   logic [3:0]  dst_in0, dst_out0;
   logic [15:0] addr0;

   // ---------------- dut1 signals ----------------
   logic [31:0] alu_in1, rm_in1, alu_out1, mdata1, wdata1, rdata1;
   logic        rd_in1, wr_in1, wb_in1, rd_out1, wb_out1, rdy1, ce_n1, we_n1;
   logic [3:0]  dst_in1, dst_out1;
   logic [15:0] addr1;

   mem_stage_sram_ctrl #(.BASE_ADDR(32'd1024), .ADDR_W(16), .WAIT_CYCLES(W0)) dut0 (
      .clk(clk), .rst(rst),
      .alu_result_in(alu_in0), .val_rm_in(rm_in0),
      .mem_read_in(rd_in0), .mem_write_in(wr_in0),
      .wb_enable_in(wb_in0), .dest_reg_in(dst_in0),
      .alu_result_out(alu_out0), .mem_data_out(mdata0),
      .mem_read_out(rd_out0), .wb_enable_out(wb_out0), .dest_reg_out(dst_out0),
      .ready(rdy0),
      .sram_addr(addr0), .sram_wdata(wdata0), .sram_rdata(rdata0),
      .sram_ce_n(ce_n0), .sram_we_n(we_n0)
   );

   mem_stage_sram_ctrl #(.BASE_ADDR(32'd1024), .ADDR_W(16), .WAIT_CYCLES(W1)) dut1 (
      .clk(clk), .rst(rst),
      .alu_result_in(alu_in1), .val_rm_in(rm_in1),
      .mem_read_in(rd_in1), .mem_write_in(wr_in1),
      .wb_enable_in(wb_in1), .dest_reg_in(dst_in1),
      .alu_result_out(alu_out1), .mem_data_out(mdata1),
      .mem_read_out(rd_out1), .wb_enable_out(wb_out1), .dest_reg_out(dst_out1),
      .ready(rdy1),
      .sram_addr(addr1), .sram_wdata(wdata1), .sram_rdata(rdata1),
      .sram_ce_n(ce_n1), .sram_we_n(we_n1)
   );

   // ---------------- SRAM models ----------------
   logic [31:0] mem0 [0:15];
   logic [31:0] mem1 [0:15];
   int acc0 = 0;
   int acc1 = 0;

   always @(posedge clk) begin
      if (ce_n0) acc0 <= 0;
      else begin
         acc0 <= acc0 + 1;
         if (!we_n0 && acc0 == W0 - 1) mem0[addr0[3:0]] <= wdata0;
      end
   end
   assign rdata0 = (!ce_n0 && we_n0 && acc0 == W0 - 1) ? mem0[addr0[3:0]] : 32'h0BAD_0BAD;

   always @(posedge clk) begin
      if (ce_n1) acc1 <= 0;
      else begin
         acc1 <= acc1 + 1;
         if (!we_n1 && acc1 == W1 - 1) mem1[addr1[3:0]] <= wdata1;
      end
   end
   assign rdata1 = (!ce_n1 && we_n1 && acc1 == W1 - 1) ? mem1[addr1[3:0]] : 32'h0BAD_0BAD;

   // ---------------- observation mux ----------------
   logic        sel = 1'b0;
   logic        o_rdy, o_ce_n, o_we_n;
   logic [15:0] o_addr;
   logic [31:0] o_wdata, o_mdata;
   logic [1:0]  o_state;
   assign o_rdy   = sel ? rdy1   : rdy0;
   assign o_ce_n  = sel ? ce_n1  : ce_n0;
   assign o_we_n  = sel ? we_n1  : we_n0;
   assign o_addr  = sel ? addr1  : addr0;
   assign o_wdata = sel ? wdata1 : wdata0;
   assign o_mdata = sel ? mdata1 : mdata0;
   assign o_state = sel ? dut1.state : dut0.state;

   // ---------------- scoreboard ----------------
   logic [31:0] exp_q[$];
   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic s, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
      if (s) begin
         rd_in1 = rd; wr_in1 = wr; alu_in1 = a; rm_in1 = d;
      end else begin
         rd_in0 = rd; wr_in0 = wr; alu_in0 = a; rm_in0 = d;
      end
   endtask

   // Issue one memory op (called just after a rising edge) and follow it to
   // its DONE cycle. Returns just after the edge that leaves DONE.
   task automatic mem_op(input string tag, input logic s, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [15:0] exp_addr, input int acc_cycles);
      int low = 0;
      int we_low = 0;
      int guard = 0;
      logic done = 1'b0;
      logic addr_seen = 1'b0;
      sel = s;
      drive(s, rd, wr, a, d);
      while (!done && guard < 40) begin
         @(negedge clk);
         guard++;
         if (!o_we_n) we_low++;
         if (!o_ce_n && !addr_seen) begin
            addr_seen = 1'b1;
            check({tag, " sram_addr"}, 32'(o_addr), 32'(exp_addr));
            if (wr) check({tag, " sram_wdata"}, o_wdata, d);
         end
         if (!o_rdy) low++;
         else if (low > 0) begin
            done = 1'b1;
            check({tag, " done_state"}, 32'(o_state), 32'(DONE));
            if (rd) check({tag, " mem_data_out"}, o_mdata, exp_q.pop_front());
         end
      end
      check({tag, " completed"}, 32'(done), 32'd1);
      check({tag, " ready_low_cycles"}, 32'(low), 32'(acc_cycles + 1));
      check({tag, " we_low_cycles"}, 32'(we_low), wr ? 32'(acc_cycles) : 32'd0);
      @(posedge clk);
      #1;
      drive(s, 1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      wb_in0 = 1'b0; dst_in0 = 4'd0; wb_in1 = 1'b0; dst_in1 = 4'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset ready", 32'(rdy0), 32'd1);
      check("reset ce_n", 32'(ce_n0), 32'd1);
      check("reset we_n", 32'(we_n0), 32'd1);
      check("reset mem_data_out", mdata0, 32'd0);
      check("reset mem_data_out w1", mdata1, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // ADD pass-through: no stall, outputs mirror inputs.
      alu_in0 = 32'h0000_0037; wb_in0 = 1'b1; dst_in0 = 4'd5;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("add ready", 32'(rdy0), 32'd1);
         check("add alu_result_out", alu_out0, 32'h0000_0037);
         check("add wb_enable_out", 32'(wb_out0), 32'd1);
         check("add dest_reg_out", 32'(dst_out0), 32'd5);
         check("add mem_read_out", 32'(rd_out0), 32'd0);
         check("add ce_n", 32'(ce_n0), 32'd1);
      end
      @(posedge clk);
      #1;
      alu_in0 = 32'd0; wb_in0 = 1'b0; dst_in0 = 4'd0;

      // STR to word 0.
      mem_op("str0", 1'b0, 1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, 16'd0, W0);
      @(negedge clk);
      check("str0 ready_after", 32'(rdy0), 32'd1);
      check("str0 model word0", mem0[0], 32'hDEAD_BEEF);
      @(posedge clk);
      #1;

      // LDR from word 0.
      exp_q.push_back(32'hDEAD_BEEF);
      mem_op("ldr0", 1'b0, 1'b1, 1'b0, 32'd1024, 32'd0, 16'd0, W0);
      check("ldr0 mem_read_out", 32'(rd_out0), 32'd0);

      // Back-to-back STR 1028 / LDR 1031, both word 1.
      mem_op("str1", 1'b0, 1'b0, 1'b1, 32'd1028, 32'h1234_5678, 16'd1, W0);
      exp_q.push_back(32'h1234_5678);
      mem_op("ldr1", 1'b0, 1'b1, 1'b0, 32'd1031, 32'd0, 16'd1, W0);
      @(negedge clk);
      check("ldr1 data_held", mdata0, 32'h1234_5678);
      @(posedge clk);
      #1;

      // Reset in the middle of an ACCESS (cnt == 2).
      drive(1'b0, 1'b0, 1'b1, 32'd1040, 32'h1111_2222);
      begin
         int g = 0;
         do begin
            @(negedge clk);
            g++;
         end while (!(dut0.state == ACCESS && dut0.cnt == 4'd2) && g < 20);
         check("midreset reached_cnt2", 32'(dut0.cnt), 32'd2);
      end
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      #1;
      check("midreset state", 32'(dut0.state), 32'(IDLE));
      check("midreset ce_n", 32'(ce_n0), 32'd1);
      check("midreset we_n", 32'(we_n0), 32'd1);
      check("midreset mem_data_out", mdata0, 32'd0);
      check("midreset ready", 32'(rdy0), 32'd1);
      @(posedge clk);
      #1;
      check("midreset cnt", 32'(dut0.cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("postreset state", 32'(dut0.state), 32'(IDLE));

      // WAIT_CYCLES=1 build: STR then LDR at 1032 (word 2).
      mem_op("w1 str2", 1'b1, 1'b0, 1'b1, 32'd1032, 32'hA5A5_1234, 16'd2, W1);
      exp_q.push_back(32'hA5A5_1234);
      mem_op("w1 ldr2", 1'b1, 1'b1, 1'b0, 32'd1032, 32'd0, 16'd2, W1);

      check("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
- MEM pipeline stage, directly downstream of EXE_stage_reg and upstream of MEM_stage_reg.
- Services LDR/STR against an external single-port synchronous SRAM with fixed multi-cycle access latency.
- Drives `ready` low to freeze the whole pipeline while an access is in flight.
- Passes the ALU result, wb_enable and dest_reg through to the MEM/WB register.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- ADDR_W, 16: SRAM word-address width.
- WAIT_CYCLES, 4: SRAM cycles per access; legal range 1..15.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- alu_result_in  in  32  byte address for loads/stores, or ALU result.
- val_rm_in  in  32  store data.
- mem_read_in  in  1  load request.
- mem_write_in  in  1  store request.
- wb_enable_in  in  1  writeback enable, pass-through.
- dest_reg_in  in  4  destination register, pass-through.
- alu_result_out  out  32  equals alu_result_in (combinational).
- mem_data_out  out  32  registered load data.
- mem_read_out  out  1  equals mem_read_in (combinational); WB uses it as the mux select.
- wb_enable_out  out  1  equals wb_enable_in (combinational).
- dest_reg_out  out  4  equals dest_reg_in (combinational).
- ready  out  1  0 = freeze IF/ID/EXE regs and hold MEM_stage_reg.
- sram_addr  out  ADDR_W  word address.
- sram_wdata  out  32  write data.
- sram_rdata  in  32  read data, valid in the last ACCESS cycle.
- sram_ce_n  out  1  chip enable, active low.
- sram_we_n  out  1  write enable, active low.

Behaviour:
- Request definition:
  - req = mem_read_in | mem_write_in.
  - Both asserted together is illegal: treat as a write and fire a sim assertion.
- Address:
  - sram_addr = (alu_result_in - BASE_ADDR) >> 2, truncated to ADDR_W.
  - Low two address bits are ignored.
  - No bounds check; wrap-around is by truncation.
- FSM states IDLE, ACCESS, DONE; 4-bit counter cnt.
- IDLE:
  - ready = ~req (combinational, so the freeze takes effect in the request cycle).
  - sram_ce_n = 1, sram_we_n = 1.
  - If req: go to ACCESS, cnt <= 0.
- ACCESS:
  - ready = 0, sram_ce_n = 0, sram_we_n = ~mem_write_in.
  - sram_addr and sram_wdata (= val_rm_in) are driven; inputs are stable because the pipeline is frozen.
  - cnt increments each cycle.
  - When cnt == WAIT_CYCLES-1: on a read, mem_data_out <= sram_rdata; go to DONE.
- DONE:
  - ready = 1, SRAM idle.
  - On the next edge the pipeline advances; go to IDLE unconditionally.
  - A back-to-back request is re-evaluated in IDLE, which costs one extra freeze cycle by design.
- Latency: a memory op holds ready low for WAIT_CYCLES+1 cycles (the request cycle plus ACCESS cycles), then ready is high for 1 cycle in DONE.
- Non-memory instructions: ready stays 1 with no added latency.
- mem_data_out holds its value until the next load completes.
- Reset (any time, including mid-ACCESS):
  - state = IDLE, cnt = 0, mem_data_out = 0.
  - sram_ce_n = 1, sram_we_n = 1.
  - ready follows IDLE rules (1 when the inputs are 0).
  - An aborted store may leave the SRAM word undefined; this is acceptable.
- sram_we_n is never low outside ACCESS.
- sram_ce_n and sram_we_n are glitch-free: both are decoded from registered state plus stable inputs.

Decomposition:
- Shared package (ca_pkg):
  - state enum IDLE/ACCESS/DONE.
  - BASE_ADDR default and data width 32.
- One sub-module: sram_model (behavioural SRAM with WAIT_CYCLES read latency, testbench only).
- The controller itself is a single module with no RTL sub-modules.

Test Plan:
1. Reset asserted mid-ACCESS (cnt=2) -> next cycle state IDLE, sram_ce_n=1, mem_data_out=0, ready=1 with no request.
2. ADD passthrough, alu_result_in=0x0000_0037, wb_enable_in=1, dest_reg_in=5 -> ready=1 every cycle; outputs mirror the inputs.
3. STR, alu_result_in=1024, val_rm_in=0xDEAD_BEEF, WAIT_CYCLES=4:
   - ready low exactly 5 cycles, then high 1 cycle.
   - sram_addr=0, sram_we_n low for exactly 4 cycles.
   - Model word 0 = 0xDEADBEEF.
4. LDR, alu_result_in=1024, after test 3 -> mem_data_out=0xDEADBEEF in the DONE cycle; ready pattern is the same as for the store.
5. STR to 1028 then LDR from 1031 back-to-back -> both target word 1; the load returns the stored value; 1 extra freeze cycle between the two ops.
6. WAIT_CYCLES=1 build, LDR from 1032 -> ready low 2 cycles; sram_addr=2; data captured correctly.
